selector_sequencer: RTL
=======================

// Module: selector_sequencer
// PURPOSE
//   Sequences the combinational Generator -> Concat -> Array_selector chain over a run of
//   consecutive num_in values. Accepts a start command (base, count), drives num_in from a
//   registered pointer and captures the selector results one index at a time. Each result is
//   presented on a valid/ready output port. Sits between the command source and the selector datapath.
// PARAMETERS
//   SIZE   16              array size; AW = $clog2(SIZE) bits per number
//   K      4               generator fan-out; BIT = $clog2(K) bits per selection
//   RW     SIZE*BIT        width of the selector result vector (derived, do not override)
// PORTS
//   clk           in   1       single clock, rising edge
//   rst           in   1       synchronous, active-high reset
//   start_valid   in   1       command valid
//   start_ready   out  1       command accepted when start_valid && start_ready
//   start_base    in   AW      first num_in value of the run
//   start_count   in   AW+1    beats in run; 0 allowed; values > SIZE clamp to SIZE
//   abort         in   1       cancel the current run
//   num_in        out  AW      to Generator.num_in; registered pointer
//   sel_results   in   RW      from Array_selector.results (combinational from num_in)
//   out_valid     out  1       result beat valid
//   out_ready     in   1       downstream accepts beat
//   out_results   out  RW      captured sel_results for out_index
//   out_index     out  AW      num_in value that produced out_results
//   out_last      out  1       final beat of run (qualified by out_valid)
//   busy          out  1       high in every state except IDLE
//   done          out  1       one-cycle pulse at normal run completion
// BEHAVIOUR
//   Reset: state=IDLE, num_in=0, out_valid=0, out_results=0, out_index=0, out_last=0,
//     busy=0, done=0, remaining=0. start_ready=1 one cycle after rst deasserts.
//   FSM IDLE -> ISSUE -> HOLD -> (ISSUE | DONE) -> IDLE.
//   IDLE: start_ready=1. On accept (cycle T): ptr<=start_base, remaining<=min(count,SIZE).
//     count==0 -> DONE at T+1. Otherwise -> ISSUE at T+1.
//   ISSUE (1 cycle): num_in==ptr is stable, so sel_results is settled.
//     out_results<=sel_results, out_index<=ptr, out_last<=(remaining==1), out_valid<=1 -> HOLD.
//   HOLD: out_* stay stable while out_valid && !out_ready.
//     On handshake: out_valid<=0, remaining<=remaining-1.
//     If out_last -> DONE. Else ptr<=(ptr+1) mod SIZE (wraps SIZE-1 -> 0) -> ISSUE.
//   DONE (1 cycle): done=1, start_ready=0 -> IDLE.
//   Latency: accept at T -> first out_valid at T+2. Steady state: at most 1 beat per 2 cycles.
//   start_ready=0 in ISSUE/HOLD/DONE; start_valid there is ignored, not queued.
//   abort in ISSUE/HOLD/DONE: -> IDLE next cycle, out_valid<=0 (the pending beat is dropped),
//     done is not pulsed. abort outranks a same-cycle handshake. abort in IDLE has no effect.
//   rst mid-run: identical to power-on reset; rst outranks abort.
//   num_in changes only when ptr is loaded or advanced; it holds its value in IDLE.
// CONFIGURATION
//   SEQ_PERF_CNT_EN defined: adds output stall_cnt[15:0], which counts cycles in HOLD with
//     out_valid && !out_ready. It saturates at 16'hFFFF, clears to 0 on start accept and on
//     rst, and holds its value after DONE/abort.
//   Undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.
// TESTING (real Generator/Concat/Array_selector, SIZE=16, K=4)
//   Reset 2 cycles -> out_valid=0, busy=0, done=0, num_in=0, start_ready=1.
//   base=14, count=4, out_ready=1 -> out_index 14,15,0,1. Each out_results equals the chain
//     output for that index. out_last only on index 1, then exactly one done pulse.
//   base=3, count=3, out_ready low 5 cycles on beat 2 -> out_* stable through the stall,
//     index 4 is delivered once, stall_cnt=5 (EN build).
//   count=0 -> no out_valid, done pulse at T+1. count=20, base=0 -> 16 beats, indices 0..15.
//   abort in HOLD of beat 2 -> IDLE next cycle, out_valid=0, no done.
//     A following start (base=7, count=1) gives one beat with index 7.
//   start_valid held during a run -> start_ready=0 and no extra run. A new command is accepted
//     only in IDLE, after done.

Source files
------------

// File: rtl/selector_sequencer.sv
// selector_sequencer: steps the Generator -> Concat -> Array_selector chain over a run of num_in
// values and returns each captured result on a valid/ready port. Define SEQ_PERF_CNT_EN for stall_cnt.
module selector_sequencer #(
    parameter  int SIZE = 16,
    parameter  int K    = 4,
    localparam int AW   = $clog2(SIZE),
    localparam int BIT  = $clog2(K),
    localparam int RW   = SIZE * BIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [AW-1:0] start_base,
    input  logic [AW:0]   start_count,
    input  logic          abort,
    output logic [AW-1:0] num_in,
    input  logic [RW-1:0] sel_results,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_results,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_inc;
    logic [AW:0]   remaining;
    logic [AW:0]   count_clamped;
    logic          accept;
    logic          kill;
    logic          handshake;

    assign start_ready   = (state == S_IDLE) && !rst;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign num_in        = ptr;

    assign accept        = start_valid && start_ready;
    assign kill          = abort && (state != S_IDLE);
    // abort outranks a handshake landing in the same cycle: that beat is dropped, not consumed
    assign handshake     = (state == S_HOLD) && out_valid && out_ready && !kill;
    assign count_clamped = (start_count > (AW+1)'(SIZE)) ? (AW+1)'(SIZE) : start_count;
    assign ptr_inc       = (ptr == AW'(SIZE - 1)) ? '0 : ptr + AW'(1);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would make results depend on statement order and mismatch synthesis.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default before the case; any path that skipped an assignment
    // in this always_comb would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = (start_count == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_next = S_HOLD;
            S_HOLD:  if (handshake) state_next = out_last ? S_DONE : S_ISSUE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (kill) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            remaining   <= '0;
            out_valid   <= 1'b0;
            out_results <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
        end else begin
            if (accept) begin
                ptr       <= start_base;
                remaining <= count_clamped;
            end
            // num_in has been stable for the whole ISSUE cycle, so sel_results is settled
            if (state == S_ISSUE && !kill) begin
                out_results <= sel_results;
                out_index   <= ptr;
                out_last    <= (remaining == (AW+1)'(1));
                out_valid   <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                remaining <= remaining - (AW+1)'(1);
                if (!out_last) ptr <= ptr_inc;
            end
            if (kill) out_valid <= 1'b0;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept)
            stall_cnt <= '0;
        else if (state == S_HOLD && out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
